// File: rtl/interleaved_mem_pkg.sv
// interleaved_mem_pkg: shared constants, bank-select positions and types for the 4-bank interleaved memory
package interleaved_mem_pkg;
  localparam int NUM_BANKS = 4;
  localparam int BANK_WORDS = 8192;
  localparam int RD_LATENCY = 2;
  localparam int BUSY_CYCLES = 4;
  localparam int BANK_LSB = 1;
  localparam int BANK_MSB = 2;
  localparam int IDX_LSB = 3;
  localparam int IDX_W = $clog2(BANK_WORDS);
  typedef logic [BANK_MSB-BANK_LSB:0] bank_t;
  function automatic bank_t bank_of(input logic [15:0] a);
    return a[BANK_MSB:BANK_LSB];
  endfunction
endpackage

// File: rtl/mem_bank.sv
// mem_bank: one bank array with write port, registered read port and busy counter (clk, rst, i_acc, i_we, i_idx, i_wdata -> o_rdata, o_busy)
module mem_bank
  import interleaved_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_acc,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata,
  output logic             o_busy
);
  logic [15:0] r_mem [BANK_WORDS];
  logic [15:0] r_rdata;
  logic [1:0]  r_cnt;
  always_ff @(posedge clk) begin
    if (i_acc & i_we) r_mem[i_idx] <= i_wdata;
    if (i_acc & ~i_we) r_rdata <= r_mem[i_idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_acc) r_cnt <= 2'(BUSY_CYCLES - 1);
    else if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
  end
  assign o_rdata = r_rdata;
  assign o_busy = |r_cnt;
endmodule

// File: rtl/interleaved_mem.sv
// interleaved_mem: 4-bank interleaved 16-bit memory, single request port (clk, rst, createdump, addr, data_in, rd, wr -> data_out, stall, busy, err)
module interleaved_mem
  import interleaved_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 createdump,
  input  logic [15:0]          addr,
  input  logic [15:0]          data_in,
  input  logic                 rd,
  input  logic                 wr,
  output logic [15:0]          data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);
  bank_t       w_bank;
  logic        w_req;
  logic        w_acc;
  logic        w_unused;
  logic [15:0] w_rdata [NUM_BANKS];
  logic        r_v1;
  logic        r_v2;
  bank_t       r_sel1;
  logic [15:0] r_d2;
  assign w_unused = createdump;
  assign w_bank = bank_of(addr);
  assign w_req = rd | wr;
  assign err = ~rst & ((rd & wr) | (w_req & addr[0]));
  assign stall = ~rst & w_req & busy[w_bank];
  assign w_acc = ~rst & w_req & ~err & ~stall;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank u_bank (
      .clk(clk),
      .rst(rst),
      .i_acc(w_acc && (w_bank == bank_t'(b))),
      .i_we(wr),
      .i_idx(addr[15:IDX_LSB]),
      .i_wdata(data_in),
      .o_rdata(w_rdata[b]),
      .o_busy(busy[b])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_sel1 <= '0;
      r_d2 <= '0;
    end else begin
      r_v1 <= w_acc & rd;
      r_sel1 <= w_bank;
      r_v2 <= r_v1;
      r_d2 <= w_rdata[r_sel1];
    end
  end
  assign data_out = r_v2 ? r_d2 : '0;
endmodule

// File: tb/tb_interleaved_mem.sv
// tb_interleaved_mem: scoreboard bench for interleaved_mem against a cycle-count reference model
module tb_interleaved_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        createdump = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;
  interleaved_mem dut (
    .clk(clk), .rst(rst), .createdump(createdump), .addr(addr), .data_in(data_in),
    .rd(rd), .wr(wr), .data_out(data_out), .stall(stall), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;
  exp_t        q[$];
  logic [15:0] model [int];
  int          last_acc [4];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          go = 1'b0;
  logic        e_stall = 1'b0;
  logic        e_err = 1'b0;
  logic [3:0]  e_busy = '0;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask
  task automatic step(input bit r, input bit rv, input bit wv, input logic [15:0] a,
                      input logic [15:0] d, output bit acc);
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    rd = rv;
    wr = wv;
    addr = a;
    data_in = d;
    createdump = 1'($urandom);
    acc = 1'b0;
    for (int b = 0; b < 4; b++) e_busy[b] = !r && ((cyc - last_acc[b]) inside {[1:3]});
    if (r) begin
      q.delete();
      for (int b = 0; b < 4; b++) last_acc[b] = -100;
      e_err = 1'b0;
      e_stall = 1'b0;
    end else begin
      e_err = (rv && wv) || ((rv || wv) && a[0]);
      e_stall = (rv || wv) && e_busy[a[2:1]];
      acc = (rv || wv) && !e_err && !e_stall;
      if (acc) begin
        last_acc[a[2:1]] = cyc;
        if (wv) model[int'(a[15:1])] = d;
        else q.push_back('{cyc + 2, model.exists(int'(a[15:1])) ? model[int'(a[15:1])] : 16'hxxxx});
      end
    end
  endtask
  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0, acc);
  endtask
  function automatic logic [15:0] pool_addr(input int i);
    logic [15:0] w;
    w = (i < 32) ? 16'(i) : 16'(16'h7FE0 + i - 32);
    return w << 1;
  endfunction
  always @(negedge clk) begin
    logic [15:0] ed;
    ed = '0;
    if (go) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        ed = q[0].data;
        q.delete(0);
      end
      chk("data_out", data_out, ed);
      chk("stall", 16'(stall), 16'(e_stall));
      chk("err", 16'(err), 16'(e_err));
      chk("busy", 16'(busy), 16'(e_busy));
    end
  end
  initial begin
    bit acc;
    int op;
    logic [15:0] a;
    for (int b = 0; b < 4; b++) last_acc[b] = -100;
    step(1, 0, 0, 16'h0, 16'h0, acc);
    go = 1'b1;
    step(1, 0, 0, 16'h0, 16'h0, acc);
    for (int i = 0; i < 48; i++) begin
      acc = 1'b0;
      while (!acc) step(0, 0, 1, pool_addr(i), 16'($urandom), acc);
    end
    idle(4);
    step(0, 0, 1, 16'h0010, 16'hBEEF, acc);
    idle(3);
    step(0, 1, 0, 16'h0010, 16'h0, acc);
    idle(4);
    step(0, 1, 0, 16'h0010, 16'h0, acc);
    acc = 1'b0;
    while (!acc) step(0, 1, 0, 16'h0018, 16'h0, acc);
    idle(4);
    step(0, 1, 0, 16'h0020, 16'h0, acc);
    step(0, 1, 0, 16'h0022, 16'h0, acc);
    step(0, 1, 0, 16'h0024, 16'h0, acc);
    step(0, 1, 0, 16'h0026, 16'h0, acc);
    idle(4);
    step(0, 1, 1, 16'h0040, 16'h1234, acc);
    step(0, 1, 0, 16'h0041, 16'h0, acc);
    idle(4);
    step(0, 1, 0, 16'h0010, 16'h0, acc);
    step(1, 0, 0, 16'h0, 16'h0, acc);
    step(0, 1, 0, 16'h0010, 16'h0, acc);
    idle(4);
    for (int i = 0; i < 2000; i++) begin
      op = int'($urandom_range(0, 9));
      a = pool_addr(int'($urandom_range(0, 47)));
      if (op < 2) step(0, 0, 0, a, 16'h0, acc);
      else if (op < 6) step(0, 1, 0, a, 16'h0, acc);
      else if (op < 9) step(0, 0, 1, a, 16'($urandom), acc);
      else if ($urandom_range(0, 1) == 0) step(0, 1, 1, a, 16'($urandom), acc);
      else step(0, 1'($urandom), 1'b0, a | 16'h1, 16'h0, acc) ;
    end
    idle(4);
    @(posedge clk);
    #1;
    go = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
